// File: rtl/regfile_wb.sv
// regfile_wb: 16 x 32-bit register file with a one-entry writeback stage.
// Results are captured from execute into wb_* on one edge and committed to
// the array on the next. r0 is hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward the pending writeback
// to the read ports when a source register matches wb_rd.
module regfile_wb (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] alu_result,
   input  logic [3:0]  modified_opcode,
   input  logic        stall,
   output logic [31:0] register1,
   output logic [31:0] register2,
   output logic        wb_valid,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned NUM_REGS = 16;

   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic              is_write_op;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_rd_q,    wb_rd_d;
   logic [DATA_W-1:0] wb_data_q,  wb_data_d;

   // Instruction bits outside the register fields are not needed here.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instruction[31:23], instruction[10:0]};

   assign rd  = instruction[22:19];
   assign rs1 = instruction[18:15];
   assign rs2 = instruction[14:11];

   // Compare (B) and the reserved/NOP opcodes (D, E, F) produce no result.
   assign is_write_op = (modified_opcode <= 4'hA) || (modified_opcode == 4'hC);

   // Capture stage: a stalled instruction never enters writeback.
   always_comb begin
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      if (!stall) begin
         wb_valid_d = is_write_op && (rd != ADDR_W'(0));
         wb_rd_d    = rd;
         wb_data_d  = alu_result;
      end
   end

   // Commit stage: a pending writeback lands regardless of stall.
   always_comb begin
      regs_d = regs_q;
      if (wb_valid_q && (wb_rd_q != ADDR_W'(0))) begin
         regs_d[wb_rd_q] = wb_data_q;
      end
   end

   // State registers; reset drops any pending writeback and clears the array.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         regs_q     <= regs_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

   // Operand read ports, optionally forwarding the pending writeback.
   always_comb begin
      register1 = (rs1 == ADDR_W'(0)) ? '0 : regs_q[rs1];
      register2 = (rs2 == ADDR_W'(0)) ? '0 : regs_q[rs2];
`ifdef REGFILE_BYPASS_EN
      if (wb_valid_q && (rs1 != ADDR_W'(0)) && (rs1 == wb_rd_q)) begin
         register1 = wb_data_q;
      end
      if (wb_valid_q && (rs2 != ADDR_W'(0)) && (rs2 == wb_rd_q)) begin
         register2 = wb_data_q;
      end
`endif
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed testbench for regfile_wb; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_wb;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] alu_result;
   logic [3:0]  modified_opcode;
   logic        stall;
   logic [31:0] register1;
   logic [31:0] register2;
   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;

   int n_total = 0;
   int n_pass  = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_wb dut (
      .clk             (clk),
      .reset           (reset),
      .instruction     (instruction),
      .alu_result      (alu_result),
      .modified_opcode (modified_opcode),
      .stall           (stall),
      .register1       (register1),
      .register2       (register2),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Present one instruction at the falling edge, then settle for sampling.
   task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [31:0] data, input logic stl);
      logic [31:0] ins;
      @(negedge clk);
      ins = '0;
      ins[22:19] = rd;
      ins[18:15] = rs1;
      ins[14:11] = rs2;
      instruction     = ins;
      modified_opcode = op;
      alu_result      = data;
      stall           = stl;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      instruction = '0;
      alu_result = '0;
      modified_opcode = 4'hF;
      stall = 1'b0;
      #12;
      check("rst_wb_valid", 32'(wb_valid), 32'h0);
      check("rst_wb_rd",    32'(wb_rd),    32'h0);
      check("rst_wb_data",  wb_data,       32'h0);
      @(negedge clk);
      reset = 1'b0;

      // All source combinations read zero after reset.
      for (int i = 0; i < 16; i++) begin
         drive(4'hF, 4'd0, 4'(i), 4'(15 - i), 32'h0, 1'b0);
         check("rst_r1", register1, 32'h0);
         check("rst_r2", register2, 32'h0);
         check("rst_wbv", 32'(wb_valid), 32'h0);
      end

      // Load immediate to r3, dependent read next cycle.
      drive(4'h6, 4'd3, 4'd0, 4'd0, 32'h1234, 1'b0);
      drive(4'h0, 4'd0, 4'd3, 4'd0, 32'h0, 1'b0);
      check("li_wbv",  32'(wb_valid), 32'h1);
      check("li_wbrd", 32'(wb_rd), 32'h3);
      check("li_wbd",  wb_data, 32'h1234);
      check("li_r1_n1", register1, BYP ? 32'h1234 : 32'h0);
      drive(4'hF, 4'd0, 4'd3, 4'd3, 32'h0, 1'b0);
      check("li_r1_n2", register1, 32'h1234);
      check("li_r2_n2", register2, 32'h1234);
      check("li_wbv_n2", 32'(wb_valid), 32'h0);

      // Compare and NOP do not write.
      drive(4'hB, 4'd5, 4'd5, 4'd6, 32'hFFFF_FFFF, 1'b0);
      drive(4'hF, 4'd6, 4'd5, 4'd6, 32'hFFFF_FFFF, 1'b0);
      check("cmp_wbv", 32'(wb_valid), 32'h0);
      drive(4'hD, 4'd5, 4'd5, 4'd6, 32'hFFFF_FFFF, 1'b0);
      check("nop_wbv", 32'(wb_valid), 32'h0);
      drive(4'hE, 4'd6, 4'd5, 4'd6, 32'hFFFF_FFFF, 1'b0);
      check("opd_wbv", 32'(wb_valid), 32'h0);
      check("cmp_r5", register1, 32'h0);
      check("nop_r6", register2, 32'h0);
      drive(4'hF, 4'd0, 4'd5, 4'd6, 32'h0, 1'b0);
      check("ope_wbv", 32'(wb_valid), 32'h0);
      check("cmp_r5_b", register1, 32'h0);
      check("nop_r6_b", register2, 32'h0);

      // Boundary writing opcodes A and C.
      drive(4'hA, 4'd10, 4'd0, 4'd0, 32'h0000_AAAA, 1'b0);
      drive(4'hC, 4'd11, 4'd0, 4'd0, 32'h0000_CCCC, 1'b0);
      check("opa_wbv", 32'(wb_valid), 32'h1);
      drive(4'hF, 4'd0, 4'd10, 4'd11, 32'h0, 1'b0);
      check("opc_wbv", 32'(wb_valid), 32'h1);
      drive(4'hF, 4'd0, 4'd10, 4'd11, 32'h0, 1'b0);
      check("opa_r10", register1, 32'h0000_AAAA);
      check("opc_r11", register2, 32'h0000_CCCC);

      // Write to r0 is dropped.
      drive(4'h0, 4'd0, 4'd0, 4'd0, 32'hDEAD_BEEF, 1'b0);
      drive(4'hF, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0);
      check("r0_wbv", 32'(wb_valid), 32'h0);
      check("r0_r1", register1, 32'h0);
      drive(4'hF, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0);
      check("r0_r1_b", register1, 32'h0);

      // Stall keeps the pending commit but drops the stalled instruction.
      drive(4'h0, 4'd7, 4'd0, 4'd0, 32'hA, 1'b0);
      drive(4'h0, 4'd7, 4'd0, 4'd0, 32'hB, 1'b1);
      check("stl_wbv", 32'(wb_valid), 32'h1);
      check("stl_wbd", wb_data, 32'hA);
      drive(4'hF, 4'd0, 4'd7, 4'd0, 32'h0, 1'b0);
      check("stl_wbv_after", 32'(wb_valid), 32'h0);
      check("stl_wbrd_hold", 32'(wb_rd), 32'h7);
      check("stl_wbd_hold", wb_data, 32'hA);
      check("stl_r7", register1, 32'hA);
      drive(4'hF, 4'd0, 4'd7, 4'd0, 32'h0, 1'b0);
      check("stl_r7_b", register1, 32'hA);

      // Back-to-back writes to r8 commit in order.
      drive(4'h0, 4'd8, 4'd0, 4'd0, 32'h1, 1'b0);
      drive(4'h0, 4'd8, 4'd0, 4'd0, 32'h2, 1'b0);
      drive(4'hF, 4'd0, 4'd8, 4'd0, 32'h0, 1'b0);
      check("b2b_r8_n1", register1, BYP ? 32'h2 : 32'h1);
      drive(4'hF, 4'd0, 4'd8, 4'd0, 32'h0, 1'b0);
      check("b2b_r8_n2", register1, 32'h2);

      // Asynchronous reset discards a pending writeback.
      drive(4'h0, 4'd9, 4'd9, 4'd7, 32'h55, 1'b0);
      @(posedge clk);
      #2;
      check("ar_wbv_pre", 32'(wb_valid), 32'h1);
      reset = 1'b1;
      #1;
      check("ar_wbv", 32'(wb_valid), 32'h0);
      check("ar_wbd", wb_data, 32'h0);
      check("ar_r7_clr", register2, 32'h0);
      drive(4'h0, 4'd9, 4'd9, 4'd7, 32'h66, 1'b0);
      @(posedge clk);
      #1;
      check("ar_hold_wbv", 32'(wb_valid), 32'h0);
      check("ar_hold_r9", register1, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      instruction = '0;
      instruction[22:19] = 4'd4;
      instruction[18:15] = 4'd9;
      modified_opcode = 4'h0;
      alu_result = 32'h77;
      #1;
      check("ar_r9_rel", register1, 32'h0);
      drive(4'hF, 4'd0, 4'd4, 4'd9, 32'h0, 1'b0);
      check("ar_first_wbv", 32'(wb_valid), 32'h1);
      check("ar_first_wbrd", 32'(wb_rd), 32'h4);
      check("ar_first_wbd", wb_data, 32'h77);
      check("ar_r4_n1", register1, BYP ? 32'h77 : 32'h0);
      check("ar_r9_n1", register2, 32'h0);
      drive(4'hF, 4'd0, 4'd4, 4'd9, 32'h0, 1'b0);
      check("ar_r4_n2", register1, 32'h77);
      check("ar_r9_n2", register2, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
